// File: rtl/shift_sequencer.sv
// Sequences one parallel-load / serial-shift transfer at a time: accepts a word
// over valid/ready, shifts it out MSB- or LSB-first for a programmable count
// while capturing serial input, then presents the result with a done pulse.
module shift_sequencer #(
  parameter  int n = 4,
  localparam int W = $clog2(n + 1)
) (
  input  logic         C,
  input  logic         nR,
  input  logic         IV,
  output logic         IR,
  input  logic [n-1:0] D,
  input  logic         RTL,
  input  logic [W-1:0] N,
  input  logic         A,
  input  logic         SI,
  output logic         SO,
  output logic         SV,
  output logic [n-1:0] Q,
  output logic         OV,
  output logic         BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t       state, state_nxt;
  logic [n-1:0] sh;
  logic [n-1:0] sh_nxt;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_eff;
  logic         dir;
  logic [n-1:0] q_r;

  // Count of zero or beyond the register width both mean a full-width transfer.
  always_comb begin
    cnt_eff = N;
    if (N == '0 || N > W'(n)) cnt_eff = W'(n);
  end

  // One shift step: vacated end of the register is filled from SI.
  always_comb begin
    sh_nxt = sh;
    if (dir) sh_nxt = {sh[n-2:0], SI};
    else     sh_nxt = {SI, sh[n-1:1]};
  end

  // State register.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath: load on accept, shift while in SHIFT, capture Q on the final
  // shift unless that same edge is aborting.
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      sh  <= '0;
      cnt <= '0;
      dir <= 1'b0;
      q_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (IV) begin
            sh  <= D;
            dir <= RTL;
            cnt <= cnt_eff;
          end
        end
        S_SHIFT: begin
          if (!A) begin
            sh  <= sh_nxt;
            cnt <= cnt - W'(1);
            if (cnt == W'(1)) q_r <= sh_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    IR        = 1'b0;
    BUSY      = 1'b0;
    SV        = 1'b0;
    SO        = 1'b0;
    OV        = 1'b0;
    case (state)
      S_IDLE: begin
        IR = 1'b1;
        if (IV) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        BUSY = 1'b1;
        SV   = 1'b1;
        SO   = dir ? sh[n-1] : sh[0];
        if (A)                   state_nxt = S_IDLE;
        else if (cnt == W'(1))   state_nxt = S_DONE;
      end
      S_DONE: begin
        BUSY      = 1'b1;
        OV        = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign Q = q_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// transfers compared against an arithmetic model of each transfer.
module tb_shift_sequencer;

  localparam int n = 4;
  localparam int W = $clog2(n + 1);

  logic         C = 1'b0;
  logic         nR;
  logic         IV;
  logic         IR;
  logic [n-1:0] D;
  logic         RTL;
  logic [W-1:0] N;
  logic         A;
  logic         SI;
  logic         SO;
  logic         SV;
  logic [n-1:0] Q;
  logic         OV;
  logic         BUSY;

  int           checks   = 0;
  int           failures = 0;
  logic [n-1:0] q_model  = '0;

  shift_sequencer #(.n(n)) dut (
    .C    (C),
    .nR   (nR),
    .IV   (IV),
    .IR   (IR),
    .D    (D),
    .RTL  (RTL),
    .N    (N),
    .A    (A),
    .SI   (SI),
    .SO   (SO),
    .SV   (SV),
    .Q    (Q),
    .OV   (OV),
    .BUSY (BUSY)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ir"},   32'(IR),   32'd1);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_sv"},   32'(SV),   32'd0);
    check({tag, "_so"},   32'(SO),   32'd0);
    check({tag, "_ov"},   32'(OV),   32'd0);
    check({tag, "_q"},    32'(Q),    32'd0);
  endtask

  // One transfer, entered and left at a falling edge with the DUT idle.
  task automatic xfer(input logic [n-1:0] d, input logic r, input logic [W-1:0] nn,
                      input logic [n-1:0] si_pat, input bit rand_si,
                      input int abort_at, input int rst_at, input bit hold_iv);
    int          k;
    int unsigned s;
    int unsigned dd;
    int unsigned qexp;
    bit          ok;
    logic        sib;
    logic [n-1:0] dv;
    k  = (nn == 0 || int'(nn) > n) ? n : int'(nn);
    dv = d;
    dd = 32'(d);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (IR) begin ok = 1'b1; break; end
      @(negedge C);
    end
    if (!ok) begin
      check("ir_wait_timeout", 32'd0, 32'd1);
      return;
    end
    check("idle_sv",   32'(SV),   32'd0);
    check("idle_busy", 32'(BUSY), 32'd0);
    check("idle_q",    32'(Q),    32'(q_model));
    IV  = 1'b1;
    D   = d;
    RTL = r;
    N   = nn;
    A   = 1'($urandom % 2);
    @(negedge C);
    A = 1'b0;
    if (!hold_iv) IV = 1'b0;
    s = 0;
    for (int i = 0; i < k; i++) begin
      check("shift_sv",   32'(SV),   32'd1);
      check("shift_busy", 32'(BUSY), 32'd0 + 32'd1);
      check("shift_ir",   32'(IR),   32'd0);
      check("shift_ov",   32'(OV),   32'd0);
      check("shift_q",    32'(Q),    32'(q_model));
      check("so_bit",     32'(SO),   32'(r ? dv[n-1-i] : dv[i]));
      sib = rand_si ? 1'($urandom % 2) : si_pat[i];
      SI  = sib;
      D   = n'($urandom);
      RTL = 1'($urandom % 2);
      N   = W'($urandom);
      if (i == rst_at) begin
        nR = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        q_model = '0;
        @(negedge C);
        check_reset_outputs("rst_held");
        nR = 1'b1;
        IV = 1'b0;
        return;
      end
      if (i == abort_at) A = 1'b1;
      if (r) s |= 32'(sib) << (k - 1 - i);
      else   s |= 32'(sib) << (n - k + i);
      @(negedge C);
      if (i == abort_at) begin
        A = 1'b0;
        check("abort_ir", 32'(IR), 32'd1);
        check("abort_ov", 32'(OV), 32'd0);
        check("abort_sv", 32'(SV), 32'd0);
        check("abort_q",  32'(Q),  32'(q_model));
        return;
      end
    end
    if (r) qexp = ((dd << k) | s) & ((32'd1 << n) - 1);
    else   qexp = (dd >> k) | s;
    check("done_ov",   32'(OV),   32'd1);
    check("done_q",    32'(Q),    qexp);
    check("done_sv",   32'(SV),   32'd0);
    check("done_so",   32'(SO),   32'd0);
    check("done_busy", 32'(BUSY), 32'd1);
    check("done_ir",   32'(IR),   32'd0);
    q_model = n'(qexp);
    A = 1'($urandom % 2);
    @(negedge C);
    A = 1'b0;
    check("post_ov",   32'(OV),   32'd0);
    check("post_ir",   32'(IR),   32'd1);
    check("post_busy", 32'(BUSY), 32'd0);
    check("post_q",    32'(Q),    32'(q_model));
  endtask

  initial begin
    nR  = 1'b0;
    IV  = 1'b0;
    D   = '0;
    RTL = 1'b0;
    N   = '0;
    A   = 1'b0;
    SI  = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge C);
    @(negedge C);
    nR = 1'b1;

    // Reset asserted in the middle of a transfer.
    xfer(4'b1011, 1'b1, 3'd0, 4'b0000, 1'b0, -1, 1, 1'b0);
    // MSB-first, full width, SI=0.
    xfer(4'b1011, 1'b1, 3'd0, 4'b0000, 1'b0, -1, -1, 1'b0);
    // LSB-first, N=4, SI=1.
    xfer(4'b1011, 1'b0, 3'd4, 4'b1111, 1'b0, -1, -1, 1'b0);
    // Two-bit transfer, SI 1 then 0 -> 1110.
    xfer(4'b1011, 1'b1, 3'd2, 4'b0001, 1'b0, -1, -1, 1'b0);
    // Count above width clamps to full width.
    xfer(4'b0110, 1'b1, 3'd7, 4'b0000, 1'b1, 1, -1, 1'b0);
    xfer(4'b1011, 1'b1, 3'd2, 4'b0001, 1'b0, -1, -1, 1'b0);
    xfer(4'b1100, 1'b0, 3'd7, 4'b1010, 1'b0, -1, -1, 1'b0);
    // Aborts: second shift cycle, then coincident with the final shift.
    xfer(4'b0101, 1'b1, 3'd0, 4'b1111, 1'b0, 1, -1, 1'b0);
    xfer(4'b0101, 1'b0, 3'd3, 4'b1111, 1'b0, 2, -1, 1'b0);
    // Back-to-back words with IV held high.
    xfer(4'b0001, 1'b1, 3'd0, 4'b0000, 1'b1, -1, -1, 1'b1);
    xfer(4'b1000, 1'b1, 3'd0, 4'b0000, 1'b1, -1, -1, 1'b1);
    IV = 1'b0;

    for (int j = 0; j < 60; j++) begin
      int ab;
      ab = ($urandom % 4 == 0) ? int'($urandom_range(0, n - 1)) : -1;
      xfer(n'($urandom), 1'($urandom % 2), W'($urandom_range(0, 7)), '0, 1'b1,
           ab, -1, 1'($urandom % 2));
      IV = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
